// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and pipe_hazard_ctrl.
// The master modport is the datapath side: it supplies decode and EX status
// and receives the stall/flush controls and perf counters.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned S = 32
);
    logic [S-1:0] id_inst;
    logic         ex_mem_read;
    logic [4:0]   ex_rt;
    logic         branch_taken;
    logic         pc_we;
    logic         ifid_we;
    logic         ifid_flush;
    logic         idex_bubble;
    logic         mdu_busy;
    logic [15:0]  perf_stall;
    logic [15:0]  perf_flush;

    modport master (
        output id_inst, ex_mem_read, ex_rt, branch_taken,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, mdu_busy,
        input  perf_stall, perf_flush
    );

    modport slave (
        input  id_inst, ex_mem_read, ex_rt, branch_taken,
        output pc_we, ifid_we, ifid_flush, idex_bubble, mdu_busy,
        output perf_stall, perf_flush
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and multiply/divide interlocks plus
// branch flush. Hazard controls are combinational; only the MDU state,
// its latency counter and the optional perf counters are registered.
// Optional feature macro: HAZ_PERF_CNT_EN enables saturating stall/flush
// counters; without it both perf outputs are tied to zero.
// Decode assumes S >= 32 (MIPS-style fields in id_inst[31:0]).
module pipe_hazard_ctrl #(
    parameter int unsigned S       = 32,
    parameter int unsigned MDU_LAT = 32
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;

    logic [31:0] inst;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt;
    logic        uses_rt, load_hz, is_mdu, is_hilo, mdu_hz;
    logic        busy, stall, issue;
    logic        unused_inst_bits;

    assign inst             = hz.id_inst[31:0];
    assign op               = inst[31:26];
    assign rs               = inst[25:21];
    assign rt               = inst[20:16];
    assign fn               = inst[5:0];
    assign unused_inst_bits = ^inst[15:6];

    assign busy    = (state_q == BUSY);
    assign uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    assign load_hz = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                     ((hz.ex_rt == rs) || (uses_rt && (hz.ex_rt == rt)));
    assign is_mdu  = (op == 6'h00) && (fn[5:2] == 4'b0110);
    assign is_hilo = (op == 6'h00) && (fn[5:2] == 4'b0100);
    assign mdu_hz  = busy && (is_mdu || is_hilo);
    assign stall   = load_hz || mdu_hz;
    assign issue   = is_mdu && !stall && !hz.branch_taken;

    // Hazard controls: reset, then branch flush, then stall, then normal flow
    always_comb begin
        hz.pc_we       = 1'b1;
        hz.ifid_we     = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_bubble = 1'b0;
        if (!reset) begin
            hz.pc_we       = 1'b0;
            hz.ifid_we     = 1'b0;
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
        end else if (hz.branch_taken) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
        end else if (stall) begin
            hz.pc_we       = 1'b0;
            hz.ifid_we     = 1'b0;
            hz.idex_bubble = 1'b1;
        end
    end

    assign hz.mdu_busy = busy;

    // MDU latency FSM next state: IDLE loads the latency on issue, BUSY counts down
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    cnt_d   = 6'(MDU_LAT);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // MDU state and latency counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_flush_q, perf_flush_d;

    // Saturating counts of flush cycles (branch) and stall cycles (no branch)
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (hz.branch_taken) begin
            if (perf_flush_q != '1) perf_flush_d = perf_flush_q + 16'd1;
        end else if (stall) begin
            if (perf_stall_q != '1) perf_stall_d = perf_stall_q + 16'd1;
        end
    end

    // Perf counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign hz.perf_stall = perf_stall_q;
    assign hz.perf_flush = perf_flush_q;
`else
    assign hz.perf_stall = '0;
    assign hz.perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with MDU_LAT=4.
// Expected controls come from a small behavioural model and are queued when
// stimulus is driven, then popped and compared at the falling clock edge.
module tb_pipe_hazard_ctrl;

    localparam int unsigned LAT = 4;

    localparam logic [31:0] ADD_I  = 32'h010A4820; // add $9,$8,$10
    localparam logic [31:0] LW_I   = 32'h8D0A0000; // lw  $10,0($8)
    localparam logic [31:0] MULT_I = 32'h01090018; // mult $8,$9
    localparam logic [31:0] MFLO_I = 32'h00006012; // mflo $12
    localparam logic [31:0] NOP_I  = 32'h00000000;

    typedef struct packed {
        logic        pc_we;
        logic        ifid_we;
        logic        ifid_flush;
        logic        idex_bubble;
        logic        mdu_busy;
        logic [15:0] ps;
        logic [15:0] pf;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    int   m_cnt   = 0;
    int   m_stall = 0;
    int   m_flush = 0;

    pipe_hazard_ctrl_if #(.S(32)) hzif ();

    pipe_hazard_ctrl #(.S(32), .MDU_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hzif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] perf_exp(input int v);
`ifdef HAZ_PERF_CNT_EN
        return 16'(v);
`else
        return 16'(v * 0);
`endif
    endfunction

    function automatic logic hazard(input logic [31:0] inst, input logic mr, input logic [4:0] ert);
        logic [5:0] op, fn;
        logic [4:0] rs, rt;
        logic ur, lh, mdu, hilo;
        op   = inst[31:26];
        rs   = inst[25:21];
        rt   = inst[20:16];
        fn   = inst[5:0];
        ur   = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'h2B);
        lh   = mr && (ert != 5'd0) && ((ert == rs) || (ur && ert == rt));
        mdu  = (op == 6'd0) && (fn >= 6'h18) && (fn <= 6'h1B);
        hilo = (op == 6'd0) && (fn >= 6'h10) && (fn <= 6'h13);
        return lh || ((m_cnt != 0) && (mdu || hilo));
    endfunction

    function automatic logic is_mult(input logic [31:0] inst);
        return (inst[31:26] == 6'd0) && (inst[5:0] >= 6'h18) && (inst[5:0] <= 6'h1B);
    endfunction

    function automatic exp_t model_out(input logic [31:0] inst, input logic mr,
                                       input logic [4:0] ert, input logic br);
        exp_t e;
        logic h;
        h = hazard(inst, mr, ert);
        e.mdu_busy = (m_cnt != 0);
        e.ps = perf_exp(m_stall);
        e.pf = perf_exp(m_flush);
        if (br)     e[36:33] = 4'b1111;
        else if (h) e[36:33] = 4'b0001;
        else        e[36:33] = 4'b1100;
        return e;
    endfunction

    function automatic exp_t reset_out();
        exp_t e;
        e = '0;
        e.ifid_flush  = 1'b1;
        e.idex_bubble = 1'b1;
        return e;
    endfunction

    task automatic model_edge(input logic [31:0] inst, input logic mr,
                              input logic [4:0] ert, input logic br);
        logic h;
        h = hazard(inst, mr, ert);
        if (br) begin
            if (m_flush < 65535) m_flush++;
        end else if (h) begin
            if (m_stall < 65535) m_stall++;
        end
        if (m_cnt != 0)                     m_cnt--;
        else if (!br && !h && is_mult(inst)) m_cnt = LAT;
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb_q.pop_front();
        check_eq({tag, ".pc_we"},       32'(hzif.pc_we),       32'(e.pc_we));
        check_eq({tag, ".ifid_we"},     32'(hzif.ifid_we),     32'(e.ifid_we));
        check_eq({tag, ".ifid_flush"},  32'(hzif.ifid_flush),  32'(e.ifid_flush));
        check_eq({tag, ".idex_bubble"}, 32'(hzif.idex_bubble), 32'(e.idex_bubble));
        check_eq({tag, ".mdu_busy"},    32'(hzif.mdu_busy),    32'(e.mdu_busy));
        check_eq({tag, ".perf_stall"},  32'(hzif.perf_stall),  32'(e.ps));
        check_eq({tag, ".perf_flush"},  32'(hzif.perf_flush),  32'(e.pf));
    endtask

    // One cycle: drive just after the rising edge, check at the falling edge
    task automatic step(input string tag, input logic [31:0] inst, input logic mr,
                        input logic [4:0] ert, input logic br);
        hzif.id_inst      = inst;
        hzif.ex_mem_read  = mr;
        hzif.ex_rt        = ert;
        hzif.branch_taken = br;
        sb_q.push_back(model_out(inst, mr, ert, br));
        @(negedge clk);
        pop_compare(tag);
        model_edge(inst, mr, ert, br);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset             = 1'b0;
        hzif.id_inst      = NOP_I;
        hzif.ex_mem_read  = 1'b0;
        hzif.ex_rt        = 5'd0;
        hzif.branch_taken = 1'b0;

        @(posedge clk);
        #1;
        sb_q.push_back(reset_out());
        pop_compare("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        step("idle",       NOP_I,  1'b0, 5'd0,  1'b0);
        step("load_rs",    ADD_I,  1'b1, 5'd8,  1'b0);
        step("load_clr",   ADD_I,  1'b0, 5'd8,  1'b0);
        step("load_r0",    ADD_I,  1'b1, 5'd0,  1'b0);
        step("load_rt",    ADD_I,  1'b1, 5'd10, 1'b0);
        step("lw_rt",      LW_I,   1'b1, 5'd10, 1'b0);
        step("lw_rs",      LW_I,   1'b1, 5'd8,  1'b0);
        step("nomatch",    ADD_I,  1'b1, 5'd11, 1'b0);

        step("mdu_issue",  MULT_I, 1'b0, 5'd0,  1'b0);
        for (int unsigned i = 0; i < LAT + 1; i++) begin
            step($sformatf("mflo%0d", i), MFLO_I, 1'b0, 5'd0, 1'b0);
        end
        step("after_mdu",  MFLO_I, 1'b0, 5'd0,  1'b0);

        step("br_on_load", ADD_I,  1'b1, 5'd8,  1'b1);
        step("br_mult",    MULT_I, 1'b0, 5'd0,  1'b1);
        step("no_issue",   NOP_I,  1'b0, 5'd0,  1'b0);

        step("mdu_issue2", MULT_I, 1'b0, 5'd0,  1'b0);
        step("br_busy",    NOP_I,  1'b0, 5'd0,  1'b1);
        step("mult_busy",  MULT_I, 1'b0, 5'd0,  1'b0);
        step("mflo_busy",  MFLO_I, 1'b0, 5'd0,  1'b0);
        step("mflo_last",  MFLO_I, 1'b0, 5'd0,  1'b0);
        step("mult_free",  MULT_I, 1'b0, 5'd0,  1'b0);

        // Counter is now LAT; two stalled cycles bring it to 2, then async reset
        step("mflo_a",     MFLO_I, 1'b0, 5'd0,  1'b0);
        step("mflo_b",     MFLO_I, 1'b0, 5'd0,  1'b0);
        reset = 1'b0;
        m_cnt   = 0;
        m_stall = 0;
        m_flush = 0;
        #1;
        sb_q.push_back(reset_out());
        pop_compare("async_rst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("mflo_post",  MFLO_I, 1'b0, 5'd0,  1'b0);
        step("flush_cnt",  NOP_I,  1'b0, 5'd0,  1'b1);

`ifdef HAZ_PERF_CNT_EN
        hzif.id_inst      = ADD_I;
        hzif.ex_mem_read  = 1'b1;
        hzif.ex_rt        = 5'd8;
        hzif.branch_taken = 1'b0;
        for (int k = 0; k < 70000; k++) begin
            model_edge(ADD_I, 1'b1, 5'd8, 1'b0);
            @(posedge clk);
        end
        #1;
        step("sat_a",      ADD_I,  1'b1, 5'd8,  1'b0);
        step("sat_b",      ADD_I,  1'b1, 5'd8,  1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
